jk_bank_driver: RTL and testbench
=================================

Name: jk_bank_driver

Overview:
- Controller that drives an external bank of W JK flip-flops to target words. Targets arrive over a valid/ready stream and are queued in a small FIFO.
- For each target it computes the per-bit J/K excitation from the bank's current Q, applies it for exactly one clock, and reads Q back to verify.
- On a mismatch it retries a bounded number of times, then flags an error.
- It sits between a pattern source and the JK register bank, on the command side of the flip-flop interface.

Parameters:
- W, 4, width of target word and of the JK bank
- DEPTH, 4, target FIFO depth (power of 2, >=2)
- MAX_RETRY, 2, re-drive attempts after the first drive before declaring an error
- USE_TOGGLE, 0, 1 = changing bits driven with J=K=1; 0 = changing bits driven with set (10) or reset (01)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- tgt_valid  in  1  target word offered
- tgt_ready  out  1  FIFO can accept (count < DEPTH)
- tgt_data  in  W  target word
- q_fb  in  W  Q outputs of the JK bank, sampled each cycle
- j_o  out  W  J inputs to the bank (registered)
- k_o  out  W  K inputs to the bank (registered)
- busy  out  1  FIFO non-empty or FSM not IDLE
- done  out  1  one-cycle pulse: target verified
- err  out  1  one-cycle pulse: target failed after all retries
- err_mask  out  W  tgt ^ q_fb captured at the failing CHECK; held until the next CHECK completes

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE; FIFO emptied; j_o=k_o=0; done=err=0; err_mask=0; retry count=0. tgt_ready=1 as soon as reset is released.
- Push: on a clk edge with tgt_valid & tgt_ready, the word enters the FIFO and is visible to the FSM in the next cycle. A push and a pop on the same edge are both honoured, with count unchanged. A push while full is ignored (tgt_ready=0).
- Excitation per bit i, with c = q_fb[i], t = target[i]:
  - c==t gives J=K=0 (hold).
  - c!=t with USE_TOGGLE=1 gives J=K=1.
  - c!=t with USE_TOGGLE=0 gives J=t, K=~t.
- FSM states:
  - IDLE: j_o=k_o=0. If the FIFO is non-empty, pop into a target register, register the excitation from the current q_fb into j_o/k_o, clear retry count, go to DRIVE.
  - DRIVE: j_o/k_o held for exactly this one cycle; the bank captures them at the closing edge. At that edge j_o/k_o are forced to 0 and the FSM goes to CHECK.
  - CHECK: j_o=k_o=0. Compare q_fb to the target.
    - Equal: done=1 next cycle, go to IDLE.
    - Unequal and retry count < MAX_RETRY: increment retry count, register a fresh excitation from the current q_fb, go to DRIVE.
    - Unequal and retry count == MAX_RETRY: err=1 next cycle, capture err_mask, go to IDLE.
    - err_mask is updated on every CHECK exit: 0 on pass, the mismatch on failure.
- Latency: accept at edge E -> pop at E+1 -> bank update at E+2 -> done/err high after E+3. Throughput is one target per 3 cycles with no retries; each retry adds 2 cycles.
- done and err are never high together. j_o and k_o are nonzero only in DRIVE.
- A target of all-equal bits still passes through DRIVE (J=K=0) and CHECK.
- Reset mid-operation: the outputs and state listed under Reset clear immediately. The in-flight target and queued entries are discarded; no done or err is emitted for them.
- Width rules: retry counter is $clog2(MAX_RETRY+1) bits wide (minimum 1). FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.

Decomposition:
- Shared package jk_pkg holds:
  - FSM state enum (IDLE, DRIVE, CHECK)
  - JK command encodings HOLD=2'b00, RST=2'b01, SET=2'b10, TGL=2'b11, matching the flip-flop's case table
  - excitation function (current bit, target bit, use_toggle) -> {J,K}
- One sub-module: jk_tgt_fifo, a synchronous FIFO with push/pop/full/empty/count. It uses the same clk and asynchronous active-low reset.

Test Plan:
- Reset held low, then released -> j_o=k_o=0, tgt_ready=1, busy=0, done=err=0, err_mask=0.
- Bank model (ideal JK), Q=0000, push 1010, USE_TOGGLE=0 -> one DRIVE cycle with j_o=1010, k_o=0000; done pulses after the 3rd edge following accept; Q=1010; err_mask=0.
- Q=1100, push 1010 -> USE_TOGGLE=0 gives j_o=0010, k_o=0100; USE_TOGGLE=1 gives j_o=k_o=0110; both end with Q=1010 and a done pulse.
- Push 6 targets back-to-back (0001, 0011, 0111, 1111, 1110, 0000) -> tgt_ready drops when count==4; 6 done pulses spaced 3 cycles apart in push order; final Q=0000; nothing lost.
- Bank model with bit0 stuck at 0, Q=0000, push 0001 -> three DRIVE cycles with j_o=0001 (1 drive + 2 retries); err pulse with err_mask=0001; no done; busy falls afterwards.
- Assert reset during the DRIVE cycle of a target with 2 more queued -> j_o=k_o=0 immediately, FIFO empty, busy=0; no done or err ever emitted for those 3 targets.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank driver: FSM states, JK command codes
// and the per-bit excitation rule.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } jk_state_e;

  // {J,K} encodings, matching the flip-flop's characteristic table
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TGL  = 2'b11;

  function automatic logic [1:0] jk_excite(input logic cur, input logic tgt,
                                           input logic use_toggle);
    logic [1:0] cmd;
    if (cur == tgt) begin
      cmd = HOLD;
    end else if (use_toggle) begin
      cmd = TGL;
    end else begin
      cmd = tgt ? SET : RST;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/jk_tgt_fifo.sv
// Small synchronous FIFO that queues target words for the JK bank driver.
module jk_tgt_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push while full is dropped; a pop while empty is ignored.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives an external JK flip-flop bank to queued target words, verifying
// each write by reading Q back and retrying a bounded number of times.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int W          = 4,
  parameter int DEPTH      = 4,
  parameter int MAX_RETRY  = 2,
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  input  logic [W-1:0] tgt_data,
  input  logic [W-1:0] q_fb,
  output logic [W-1:0] j_o,
  output logic [W-1:0] k_o,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] err_mask
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

  jk_state_e state_q, state_d;
  logic [W-1:0]  tgt_q, tgt_d;
  logic [W-1:0]  j_q, j_d, k_q, k_d;
  logic [W-1:0]  err_mask_q, err_mask_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          done_q, done_d, err_q, err_d;

  logic [W-1:0]             fifo_data;
  logic                     fifo_full, fifo_empty, pop;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic [W-1:0]             exc_tgt, j_exc, k_exc;
  logic [1:0]               jk_bits;

  jk_tgt_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tgt_valid),
    .data_i  (tgt_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tgt_ready = !fifo_full;
  assign busy      = (fifo_count != '0) || (state_q != IDLE);
  assign j_o       = j_q;
  assign k_o       = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_mask  = err_mask_q;

  // In IDLE the excitation targets the FIFO head being popped; on retry it
  // targets the word already latched.
  assign exc_tgt = (state_q == IDLE) ? fifo_data : tgt_q;

  always_comb begin
    j_exc   = '0;
    k_exc   = '0;
    jk_bits = HOLD;
    for (int i = 0; i < W; i++) begin
      jk_bits  = jk_excite(q_fb[i], exc_tgt[i], USE_TOGGLE);
      j_exc[i] = jk_bits[1];
      k_exc[i] = jk_bits[0];
    end
  end

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    j_d        = '0;
    k_d        = '0;
    retry_d    = retry_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_mask_d = err_mask_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          tgt_d   = fifo_data;
          j_d     = j_exc;
          k_d     = k_exc;
          retry_d = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (q_fb == tgt_q) begin
          done_d     = 1'b1;
          err_mask_d = '0;
          state_d    = IDLE;
        end else if (retry_q < MAX_RETRY_C) begin
          retry_d = retry_q + 1'b1;
          j_d     = j_exc;
          k_d     = k_exc;
          state_d = DRIVE;
        end else begin
          err_d      = 1'b1;
          err_mask_d = q_fb ^ tgt_q;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      retry_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      retry_q    <= retry_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_mask_q <= err_mask_d;
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed self-checking bench for jk_bank_driver, with ideal JK bank models
// for a set/reset-mode instance and a toggle-mode instance.
module tb_jk_bank_driver;

  logic       clk;
  logic       rstN;
  logic       tgtValid;
  logic [3:0] tgtData;

  logic       readyS, busyS, doneS, errS;
  logic [3:0] jS, kS, errMaskS, qFbS;
  logic       readyT, busyT, doneT, errT;
  logic [3:0] jT, kT, errMaskT, qFbT;

  logic [3:0] bankS, bankT;
  logic [3:0] stuckMask;
  logic       loadEn;
  logic [3:0] loadVal;

  int assertCount;
  int failCount;

  // Free-running 10-time-unit clock shared by both instances.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set/reset-mode driver under test.
  jk_bank_driver #(.W(4), .DEPTH(4), .MAX_RETRY(2), .USE_TOGGLE(1'b0)) dut (
    .clk(clk), .reset(rstN), .tgt_valid(tgtValid), .tgt_ready(readyS),
    .tgt_data(tgtData), .q_fb(qFbS), .j_o(jS), .k_o(kS), .busy(busyS),
    .done(doneS), .err(errS), .err_mask(errMaskS)
  );

  // Toggle-mode driver fed the same stimulus.
  jk_bank_driver #(.W(4), .DEPTH(4), .MAX_RETRY(2), .USE_TOGGLE(1'b1)) dutT (
    .clk(clk), .reset(rstN), .tgt_valid(tgtValid), .tgt_ready(readyT),
    .tgt_data(tgtData), .q_fb(qFbT), .j_o(jT), .k_o(kT), .busy(busyT),
    .done(doneT), .err(errT), .err_mask(errMaskT)
  );

  // Ideal JK flip-flop next-state, one bit at a time.
  function automatic logic [3:0] jkNext(input logic [3:0] q, input logic [3:0] j,
                                        input logic [3:0] k);
    logic [3:0] n;
    n = q;
    for (int i = 0; i < 4; i++) begin
      case ({j[i], k[i]})
        2'b01:   n[i] = 1'b0;
        2'b10:   n[i] = 1'b1;
        2'b11:   n[i] = ~q[i];
        default: n[i] = q[i];
      endcase
    end
    return n;
  endfunction

  // The bank registers: a preload port for setting Q directly, otherwise
  // ideal JK behaviour; stuckMask pins bits of the set/reset bank to 0.
  always @(posedge clk) begin
    if (loadEn) begin
      bankS <= loadVal & ~stuckMask;
      bankT <= loadVal;
    end else begin
      bankS <= jkNext(bankS, jS, kS) & ~stuckMask;
      bankT <= jkNext(bankT, jT, kT);
    end
  end

  assign qFbS = bankS;
  assign qFbT = bankT;

  task automatic applyStimulus(input logic valid, input logic [3:0] data);
    tgtValid = valid;
    tgtData  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadBank(input logic [3:0] value);
    loadEn  = 1'b1;
    loadVal = value;
    tick();
    loadEn  = 1'b0;
  endtask

  // Directed sequence: reset, single targets in both modes, a burst that
  // fills the FIFO, a stuck bit exhausting retries, and reset mid-drive.
  initial begin
    logic [3:0] burst [6];
    int doneIdx;
    int lastDone;
    int driveCount;
    int doneCount;
    int errCount;
    int bothCount;
    logic [3:0] capturedMask;

    burst[0] = 4'b0001; burst[1] = 4'b0011; burst[2] = 4'b0111;
    burst[3] = 4'b1111; burst[4] = 4'b1110; burst[5] = 4'b0000;
    assertCount = 0;
    failCount   = 0;
    stuckMask   = 4'b0000;
    loadEn      = 1'b0;
    loadVal     = 4'b0000;
    rstN        = 1'b0;
    applyStimulus(1'b0, 4'b0000);

    tick();
    tick();
    rstN = 1'b1;
    #1;
    checkOutput("reset_j", 32'(jS), 32'h0);
    checkOutput("reset_k", 32'(kS), 32'h0);
    checkOutput("reset_ready", 32'(readyS), 32'h1);
    checkOutput("reset_busy", 32'(busyS), 32'h0);
    checkOutput("reset_done", 32'(doneS), 32'h0);
    checkOutput("reset_err", 32'(errS), 32'h0);
    checkOutput("reset_errmask", 32'(errMaskS), 32'h0);

    $display("[TB] single target 1010 from Q=0000");
    loadBank(4'b0000);
    applyStimulus(1'b1, 4'b1010);
    tick();
    applyStimulus(1'b0, 4'b0000);
    checkOutput("t1_busy_after_accept", 32'(busyS), 32'h1);
    checkOutput("t1_j_before_pop", 32'(jS), 32'h0);
    tick();
    checkOutput("t1_drive_j", 32'(jS), 32'b1010);
    checkOutput("t1_drive_k", 32'(kS), 32'b0000);
    tick();
    checkOutput("t1_check_j", 32'(jS), 32'h0);
    checkOutput("t1_bank_q", 32'(qFbS), 32'b1010);
    checkOutput("t1_no_early_done", 32'(doneS), 32'h0);
    tick();
    checkOutput("t1_done", 32'(doneS), 32'h1);
    checkOutput("t1_err", 32'(errS), 32'h0);
    checkOutput("t1_errmask", 32'(errMaskS), 32'h0);
    tick();
    checkOutput("t1_done_one_cycle", 32'(doneS), 32'h0);
    checkOutput("t1_idle_busy", 32'(busyS), 32'h0);

    $display("[TB] target 1010 from Q=1100, both excitation modes");
    loadBank(4'b1100);
    applyStimulus(1'b1, 4'b1010);
    tick();
    applyStimulus(1'b0, 4'b0000);
    tick();
    checkOutput("t2_sr_j", 32'(jS), 32'b0010);
    checkOutput("t2_sr_k", 32'(kS), 32'b0100);
    checkOutput("t2_tgl_j", 32'(jT), 32'b0110);
    checkOutput("t2_tgl_k", 32'(kT), 32'b0110);
    tick();
    tick();
    checkOutput("t2_sr_done", 32'(doneS), 32'h1);
    checkOutput("t2_tgl_done", 32'(doneT), 32'h1);
    checkOutput("t2_sr_q", 32'(qFbS), 32'b1010);
    checkOutput("t2_tgl_q", 32'(qFbT), 32'b1010);
    tick();

    $display("[TB] burst of six targets");
    loadBank(4'b0000);
    doneIdx  = 0;
    lastDone = -100;
    for (int cyc = 0; cyc < 26; cyc++) begin
      if (cyc < 6) applyStimulus(1'b1, burst[cyc]);
      else applyStimulus(1'b0, 4'b0000);
      tick();
      if (cyc == 4) checkOutput("t3_ready_before_full", 32'(readyS), 32'h1);
      if (cyc == 5) checkOutput("t3_ready_when_full", 32'(readyS), 32'h0);
      if (doneS) begin
        if (doneIdx < 6) checkOutput("t3_done_order_q", 32'(qFbS), 32'(burst[doneIdx]));
        if (doneIdx > 0) checkOutput("t3_done_spacing", 32'(cyc - lastDone), 32'd3);
        lastDone = cyc;
        doneIdx++;
      end
    end
    checkOutput("t3_done_count", 32'(doneIdx), 32'd6);
    checkOutput("t3_final_q", 32'(qFbS), 32'b0000);
    checkOutput("t3_final_busy", 32'(busyS), 32'h0);

    $display("[TB] bit0 stuck at 0, target 0001");
    stuckMask = 4'b0001;
    loadBank(4'b0000);
    applyStimulus(1'b1, 4'b0001);
    tick();
    applyStimulus(1'b0, 4'b0000);
    driveCount   = 0;
    doneCount    = 0;
    errCount     = 0;
    capturedMask = 4'b0000;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (jS == 4'b0001 && kS == 4'b0000) driveCount++;
      if (doneS) doneCount++;
      if (errS) begin
        errCount++;
        capturedMask = errMaskS;
      end
      tick();
    end
    checkOutput("t4_drive_cycles", 32'(driveCount), 32'd3);
    checkOutput("t4_err_pulses", 32'(errCount), 32'd1);
    checkOutput("t4_no_done", 32'(doneCount), 32'd0);
    checkOutput("t4_errmask", 32'(capturedMask), 32'b0001);
    checkOutput("t4_errmask_held", 32'(errMaskS), 32'b0001);
    checkOutput("t4_busy_after", 32'(busyS), 32'h0);
    stuckMask = 4'b0000;

    $display("[TB] reset during drive with two targets queued");
    loadBank(4'b0000);
    applyStimulus(1'b1, 4'b0011);
    tick();
    applyStimulus(1'b1, 4'b0101);
    tick();
    applyStimulus(1'b1, 4'b0110);
    tick();
    applyStimulus(1'b1, 4'b0111);
    tick();
    applyStimulus(1'b0, 4'b0000);
    checkOutput("t5_first_done", 32'(doneS), 32'h1);
    tick();
    checkOutput("t5_second_drive_j", 32'(jS), 32'b0100);
    checkOutput("t5_second_drive_k", 32'(kS), 32'b0010);
    rstN = 1'b0;
    #1;
    checkOutput("t5_reset_j", 32'(jS), 32'h0);
    checkOutput("t5_reset_k", 32'(kS), 32'h0);
    checkOutput("t5_reset_busy", 32'(busyS), 32'h0);
    checkOutput("t5_reset_ready", 32'(readyS), 32'h1);
    tick();
    tick();
    rstN = 1'b1;
    doneCount = 0;
    errCount  = 0;
    bothCount = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      tick();
      if (doneS) doneCount++;
      if (errS) errCount++;
      if (doneS && errS) bothCount++;
    end
    checkOutput("t5_no_done_after_reset", 32'(doneCount), 32'd0);
    checkOutput("t5_no_err_after_reset", 32'(errCount), 32'd0);
    checkOutput("t5_busy_idle", 32'(busyS), 32'h0);
    checkOutput("t5_done_err_exclusive", 32'(bothCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
